ssram_port_arbiter: RTL and testbench

Shares one synchronous single-port SRAM between two requesters.
- Port A: the AHB-to-SSRAM bridge's SRAM-side outputs. Port A cannot be stalled, so it has absolute priority.
- Port B: a valid/ready requester, such as a DMA or debug engine. Port B requests go through a one-entry holding buffer and are issued in cycles when port A leaves the SRAM idle.
- Read data for port B returns with a one-cycle-latency valid strobe.

---
 rtl/ssram_port_arbiter_if.sv | 58 +++++
 rtl/ssram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ssram_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ssram_port_arbiter_if.sv
// Signal bundle between the SSRAM port arbiter and its requesters/SRAM.
// slave = arbiter side, master = environment side; b_starve_cnt exists only with B_STARVE_CNT_EN.
interface ssram_port_arbiter_if #(
    parameter int unsigned AW = 12
`ifdef B_STARVE_CNT_EN
    , parameter int unsigned CW = 8
`endif
);
    logic [AW-1:0] a_addr;
    logic          a_en;
    logic [3:0]    a_enb;
    logic [3:0]    a_wb;
    logic          a_we;
    logic [31:0]   a_din;
    logic [31:0]   a_dout;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic          b_we;
    logic [3:0]    b_wb;
    logic [31:0]   b_din;
    logic          b_rvalid;
    logic [31:0]   b_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_en;
    logic [3:0]    sram_enb;
    logic [3:0]    sram_wb;
    logic          sram_we;
    logic [31:0]   sram_din;
    logic [31:0]   sram_dout;
`ifdef B_STARVE_CNT_EN
    logic [CW-1:0] b_starve_cnt;
`endif

    modport slave (
`ifdef B_STARVE_CNT_EN
        output b_starve_cnt,
`endif
        input  a_addr, a_en, a_enb, a_wb, a_we, a_din,
        output a_dout,
        input  b_valid, b_addr, b_we, b_wb, b_din,
        output b_ready, b_rvalid, b_rdata,
        output sram_addr, sram_en, sram_enb, sram_wb, sram_we, sram_din,
        input  sram_dout
    );

    modport master (
`ifdef B_STARVE_CNT_EN
        input  b_starve_cnt,
`endif
        output a_addr, a_en, a_enb, a_wb, a_we, a_din,
        input  a_dout,
        output b_valid, b_addr, b_we, b_wb, b_din,
        input  b_ready, b_rvalid, b_rdata,
        input  sram_addr, sram_en, sram_enb, sram_wb, sram_we, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/ssram_port_arbiter.sv
// Shares one single-port SSRAM between port A (bridge, absolute priority) and a buffered valid/ready port B.
// Optional macro B_STARVE_CNT_EN adds a saturating port-B wait-cycle counter (b_starve_cnt).
module ssram_port_arbiter #(
    parameter int unsigned AW = 12
`ifdef B_STARVE_CNT_EN
    , parameter int unsigned CW = 8
`endif
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    ssram_port_arbiter_if.slave bus
);
    logic          pend_q, pend_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    wb_q, wb_d;
    logic [31:0]   din_q, din_d;
    logic          rd_b_q, rd_b_d;
    logic          issue_b;
    logic          accept;

    // B only uses cycles A leaves idle, so A's read data is never clobbered.
    assign issue_b     = pend_q & ~bus.a_en;
    assign bus.b_ready = ~pend_q | issue_b;
    assign accept      = bus.b_valid & bus.b_ready;

    assign bus.a_dout   = bus.sram_dout;
    assign bus.b_rdata  = bus.sram_dout;
    assign bus.b_rvalid = rd_b_q;

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        we_d   = we_q;
        wb_d   = wb_q;
        din_d  = din_q;
        if (accept) begin
            pend_d = 1'b1;
            addr_d = bus.b_addr;
            we_d   = bus.b_we;
            wb_d   = bus.b_wb;
            din_d  = bus.b_din;
        end else if (issue_b) begin
            pend_d = 1'b0;
        end
        rd_b_d = issue_b & ~we_q;
    end

    always_comb begin
        bus.sram_addr = '0;
        bus.sram_en   = 1'b0;
        bus.sram_enb  = '0;
        bus.sram_wb   = '0;
        bus.sram_we   = 1'b0;
        bus.sram_din  = '0;
        if (bus.a_en) begin
            bus.sram_addr = bus.a_addr;
            bus.sram_en   = 1'b1;
            bus.sram_enb  = bus.a_enb;
            bus.sram_wb   = bus.a_wb;
            bus.sram_we   = bus.a_we;
            bus.sram_din  = bus.a_din;
        end else if (issue_b) begin
            bus.sram_addr = addr_q;
            bus.sram_en   = 1'b1;
            bus.sram_enb  = wb_q;
            bus.sram_wb   = we_q ? wb_q : 4'b0000;
            bus.sram_we   = we_q;
            bus.sram_din  = din_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            we_q   <= 1'b0;
            wb_q   <= '0;
            din_q  <= '0;
            rd_b_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            wb_q   <= wb_d;
            din_q  <= din_d;
            rd_b_q <= rd_b_d;
        end
    end

`ifdef B_STARVE_CNT_EN
    logic [CW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (issue_b)
            starve_d = '0;
        else if (pend_q && bus.a_en && !(&starve_q))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

    assign bus.b_starve_cnt = starve_q;
`endif
endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Directed self-checking bench for ssram_port_arbiter with a behavioural SSRAM model.
module tb_ssram_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ssram_port_arbiter_if #(
        .AW(12)
`ifdef B_STARVE_CNT_EN
        , .CW(8)
`endif
    ) bus ();

    ssram_port_arbiter #(
        .AW(12)
`ifdef B_STARVE_CNT_EN
        , .CW(8)
`endif
    ) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .bus(bus)
    );

    // SSRAM model: registered read data that holds when not read
    logic [31:0] mem [0:4095];
    logic [31:0] sram_q;
    assign bus.sram_dout = sram_q;

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.sram_wb[i]) mem[bus.sram_addr][8*i +: 8] <= bus.sram_din[8*i +: 8];
            end else begin
                sram_q <= mem[bus.sram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_addr = '0; bus.a_en = 1'b0; bus.a_enb = '0; bus.a_wb = '0;
        bus.a_we = 1'b0; bus.a_din = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_we = 1'b0; bus.b_wb = '0; bus.b_din = '0;
    endtask

    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        bus.a_en = 1'b1; bus.a_we = 1'b1; bus.a_enb = 4'hF; bus.a_wb = 4'hF;
        bus.a_addr = addr; bus.a_din = data;
        tick();
        idle_inputs();
    endtask

    task automatic b_req(input logic [11:0] addr, input logic we, input logic [31:0] din);
        bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_we = we; bus.b_wb = 4'hF; bus.b_din = din;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b expected 1", bus.b_ready); end
        checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid: got %b expected 0", bus.b_rvalid); end
        checks++; if ({bus.sram_en, bus.sram_we, bus.sram_wb, bus.sram_enb, bus.sram_addr} !== 22'h0)
            begin errors++; $display("FAIL reset_sram: got en=%b we=%b wb=%h enb=%h addr=%h expected all 0",
                bus.sram_en, bus.sram_we, bus.sram_wb, bus.sram_enb, bus.sram_addr); end
`ifdef B_STARVE_CNT_EN
        checks++; if (bus.b_starve_cnt !== 8'd0) begin errors++; $display("FAIL reset_starve: got %0d expected 0", bus.b_starve_cnt); end
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_b_write();
        b_req(12'h010, 1'b1, 32'hDEADBEEF);
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", bus.b_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if ({bus.sram_en, bus.sram_we, bus.sram_wb} !== 6'b11_1111)
            begin errors++; $display("FAIL wr_ctrl: got en=%b we=%b wb=%h expected 1 1 f", bus.sram_en, bus.sram_we, bus.sram_wb); end
        checks++; if (bus.sram_addr !== 12'h010) begin errors++; $display("FAIL wr_addr: got %h expected 010", bus.sram_addr); end
        checks++; if (bus.sram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_din: got %h expected deadbeef", bus.sram_din); end
        tick();
        checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL wr_done_idle: got sram_en=%b expected 0", bus.sram_en); end
    endtask

    task automatic test_b_read();
        b_req(12'h010, 1'b0, 32'h0);
        tick();
        idle_inputs();
        #1;
        checks++; if ({bus.sram_en, bus.sram_we, bus.sram_wb, bus.sram_enb} !== 10'b10_0000_1111)
            begin errors++; $display("FAIL rd_issue: got en=%b we=%b wb=%h enb=%h expected 1 0 0 f",
                bus.sram_en, bus.sram_we, bus.sram_wb, bus.sram_enb); end
        checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 0", bus.b_rvalid); end
        tick();
        checks++; if (bus.b_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", bus.b_rvalid); end
        checks++; if (bus.b_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", bus.b_rdata); end
        tick();
        checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b expected 0", bus.b_rvalid); end
    endtask

    task automatic test_contention();
        preload(12'h030, 32'h12345678);
        b_req(12'h030, 1'b0, 32'h0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            idle_inputs();
            bus.a_en = 1'b1; bus.a_addr = 12'h100 + 12'(c); bus.a_enb = 4'hF;
            if (c == 2) b_req(12'h077, 1'b1, 32'hBAD0BAD0);
            #1;
            checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL cont_ready c%0d: got %b expected 0", c, bus.b_ready); end
            checks++; if (bus.sram_addr !== 12'h100 + 12'(c) || bus.sram_we !== 1'b0)
                begin errors++; $display("FAIL cont_a_pass c%0d: got addr=%h we=%b expected %h 0", c, bus.sram_addr, bus.sram_we, 12'h100 + 12'(c)); end
`ifdef B_STARVE_CNT_EN
            checks++; if (bus.b_starve_cnt !== 8'(c - 1)) begin errors++; $display("FAIL cont_starve c%0d: got %0d expected %0d", c, bus.b_starve_cnt, c - 1); end
`endif
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (bus.sram_en !== 1'b1 || bus.sram_addr !== 12'h030 || bus.sram_we !== 1'b0)
            begin errors++; $display("FAIL cont_issue: got en=%b addr=%h we=%b expected 1 030 0", bus.sram_en, bus.sram_addr, bus.sram_we); end
`ifdef B_STARVE_CNT_EN
        checks++; if (bus.b_starve_cnt !== 8'd5) begin errors++; $display("FAIL cont_starve_peak: got %0d expected 5", bus.b_starve_cnt); end
`endif
        tick();
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h12345678)
            begin errors++; $display("FAIL cont_rdata: got rvalid=%b data=%h expected 1 12345678", bus.b_rvalid, bus.b_rdata); end
`ifdef B_STARVE_CNT_EN
        checks++; if (bus.b_starve_cnt !== 8'd0) begin errors++; $display("FAIL cont_starve_clr: got %0d expected 0", bus.b_starve_cnt); end
`endif
        checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL cont_no_ghost: got sram_en=%b expected 0", bus.sram_en); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'hA0A0_0000; exp_d[1] = 32'hB1B1_0001; exp_d[2] = 32'hC2C2_0002; exp_d[3] = 32'hD3D3_0003;
        for (int i = 0; i < 4; i++) preload(12'(i), exp_d[i]);
        for (int c = 0; c <= 6; c++) begin
            idle_inputs();
            if (c < 4) b_req(12'(c), 1'b0, 32'h0);
            #1;
            if (c < 4) begin
                checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected 1", c, bus.b_ready); end
            end
            if (c >= 1 && c <= 4) begin
                checks++; if (bus.sram_en !== 1'b1 || bus.sram_addr !== 12'(c - 1))
                    begin errors++; $display("FAIL b2b_issue c%0d: got en=%b addr=%h expected 1 %h", c, bus.sram_en, bus.sram_addr, 12'(c - 1)); end
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== exp_d[c - 2])
                    begin errors++; $display("FAIL b2b_rdata c%0d: got rvalid=%b data=%h expected 1 %h", c, bus.b_rvalid, bus.b_rdata, exp_d[c - 2]); end
            end
            if (c == 6) begin
                checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rvalid=%b expected 0", bus.b_rvalid); end
            end
            tick();
        end
    endtask

    task automatic test_a_then_b();
        preload(12'h020, 32'hA5A5_0020);
        preload(12'h040, 32'hCAFE_0040);
        b_req(12'h040, 1'b0, 32'h0);
        tick();
        idle_inputs();
        bus.a_en = 1'b1; bus.a_we = 1'b0; bus.a_addr = 12'h020; bus.a_enb = 4'hF;
        #1;
        checks++; if (bus.sram_addr !== 12'h020 || bus.b_ready !== 1'b0)
            begin errors++; $display("FAIL ab_a_wins: got addr=%h ready=%b expected 020 0", bus.sram_addr, bus.b_ready); end
        tick();
        idle_inputs();
        #1;
        checks++; if (bus.a_dout !== 32'hA5A5_0020) begin errors++; $display("FAIL ab_a_dout: got %h expected a5a50020", bus.a_dout); end
        checks++; if (bus.sram_en !== 1'b1 || bus.sram_addr !== 12'h040)
            begin errors++; $display("FAIL ab_b_issue: got en=%b addr=%h expected 1 040", bus.sram_en, bus.sram_addr); end
        tick();
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'hCAFE_0040)
            begin errors++; $display("FAIL ab_b_rdata: got rvalid=%b data=%h expected 1 cafe0040", bus.b_rvalid, bus.b_rdata); end
        tick();
    endtask

    task automatic test_reset_midop();
        b_req(12'h000, 1'b0, 32'h0);
        tick();
        b_req(12'h001, 1'b0, 32'h0);
        tick();
        idle_inputs();
        bus.a_en = 1'b1; bus.a_addr = 12'h200;
        #1;
        checks++; if (bus.b_ready !== 1'b0 || bus.b_rvalid !== 1'b1)
            begin errors++; $display("FAIL mid_setup: got ready=%b rvalid=%b expected 0 1", bus.b_ready, bus.b_rvalid); end
        rst_n = 1'b0;
        bus.a_en = 1'b0;
        #1;
        checks++; if (bus.b_rvalid !== 1'b0 || bus.b_ready !== 1'b1)
            begin errors++; $display("FAIL mid_async: got rvalid=%b ready=%b expected 0 1", bus.b_rvalid, bus.b_ready); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.sram_en !== 1'b0 || bus.b_rvalid !== 1'b0)
                begin errors++; $display("FAIL mid_after c%0d: got sram_en=%b rvalid=%b expected 0 0", c, bus.sram_en, bus.b_rvalid); end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sram_q = '0;
        test_reset();
        test_b_write();
        test_b_read();
        test_contention();
        test_back_to_back();
        test_a_then_b();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
